// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : sequencer state encoding and decoded opcode values
// Rev 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_BRANCH  = 3'd5,
        ST_ADVANCE = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BR  = 4'hD;
    localparam logic [3:0] OP_BRZ = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : Moore instruction fetch/decode/execute sequencer
// Rev 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ROM_WAIT = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [3:0] OPCODE,
    input  logic       I_Flag,
    input  logic [6:0] ImediateADDR,
    input  logic       ZERO,
    input  logic       EXEC_ACK,
    output logic       ROM_CS,
    output logic       ROM_OE,
    output logic       IR_EN,
    output logic       PC_EN,
    output logic       LOAD_EN,
    output logic [4:0] InstADDR,
    output logic       EXEC_REQ,
    output logic       HALTED,
    output logic [7:0] RETIRED
);

    localparam logic [2:0] WAIT_LAST = 3'(ROM_WAIT - 1);

    state_t     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic [7:0] retired_q, retired_d;
    logic [4:0] inst_addr_q, inst_addr_d;

    // Immediate flag and the upper branch bits only matter to the datapath.
    logic unused_mir;
    assign unused_mir = ^{I_Flag, ImediateADDR[6:5]};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            wait_q      <= 3'd0;
            retired_q   <= 8'd0;
            inst_addr_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        retired_d   = retired_q;
        inst_addr_d = inst_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = 3'd0;
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_LOAD: state_d = ST_DECODE;
            ST_DECODE: begin
                // Target is captured so InstADDR stays a registered output.
                inst_addr_d = ImediateADDR[4:0];
                case (OPCODE)
                    OP_HLT:  state_d = ST_HALT;
                    OP_BR:   state_d = ST_BRANCH;
                    OP_BRZ:  state_d = ZERO ? ST_BRANCH : ST_ADVANCE;
                    OP_NOP:  state_d = ST_ADVANCE;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (EXEC_ACK) state_d = ST_ADVANCE;
            end
            ST_BRANCH:  state_d = ST_FETCH;
            ST_ADVANCE: state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase

        if ((state_d == ST_ADVANCE || state_d == ST_BRANCH) &&
            (state_d != state_q) && (retired_q != 8'hFF)) begin
            retired_d = retired_q + 8'd1;
        end
    end

    always_comb begin
        ROM_CS   = 1'b0;
        ROM_OE   = 1'b0;
        IR_EN    = 1'b0;
        PC_EN    = 1'b0;
        LOAD_EN  = 1'b0;
        EXEC_REQ = 1'b0;
        HALTED   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ROM_CS = 1'b1;
                ROM_OE = 1'b1;
            end
            ST_LOAD: begin
                ROM_CS = 1'b1;
                ROM_OE = 1'b1;
                IR_EN  = 1'b1;
            end
            ST_EXEC:    EXEC_REQ = 1'b1;
            ST_BRANCH:  LOAD_EN  = 1'b1;
            ST_ADVANCE: PC_EN    = 1'b1;
            ST_HALT:    HALTED   = 1'b1;
            default: ;
        endcase
    end

    assign InstADDR = inst_addr_q;
    assign RETIRED  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : table-driven check of fetch_sequencer sequencing
// Rev 1.0
// ============================================================================
module tb_fetch_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RST_N2 = 1'b0;
    logic       START = 1'b0;
    logic       START2 = 1'b0;
    logic [3:0] OPCODE = 4'h0;
    logic       I_Flag = 1'b0;
    logic [6:0] ImediateADDR = 7'h0;
    logic       ZERO = 1'b0;
    logic       EXEC_ACK = 1'b0;

    logic       d1_rom_cs, d1_rom_oe, d1_ir_en, d1_pc_en, d1_load_en, d1_exec_req, d1_halted;
    logic [4:0] d1_inst_addr;
    logic [7:0] d1_retired;
    logic       d2_rom_cs, d2_rom_oe, d2_ir_en, d2_pc_en, d2_load_en, d2_exec_req, d2_halted;
    logic [4:0] d2_inst_addr;
    logic [7:0] d2_retired;

    fetch_sequencer #(.ROM_WAIT(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .OPCODE(OPCODE), .I_Flag(I_Flag),
        .ImediateADDR(ImediateADDR), .ZERO(ZERO), .EXEC_ACK(EXEC_ACK),
        .ROM_CS(d1_rom_cs), .ROM_OE(d1_rom_oe), .IR_EN(d1_ir_en), .PC_EN(d1_pc_en),
        .LOAD_EN(d1_load_en), .InstADDR(d1_inst_addr), .EXEC_REQ(d1_exec_req),
        .HALTED(d1_halted), .RETIRED(d1_retired)
    );

    fetch_sequencer #(.ROM_WAIT(3)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N2), .START(START2), .OPCODE(OPCODE), .I_Flag(I_Flag),
        .ImediateADDR(ImediateADDR), .ZERO(ZERO), .EXEC_ACK(EXEC_ACK),
        .ROM_CS(d2_rom_cs), .ROM_OE(d2_rom_oe), .IR_EN(d2_ir_en), .PC_EN(d2_pc_en),
        .LOAD_EN(d2_load_en), .InstADDR(d2_inst_addr), .EXEC_REQ(d2_exec_req),
        .HALTED(d2_halted), .RETIRED(d2_retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic       zero;
        logic [6:0] imm;
        int         ack_delay;
        logic       stray_ack;
        int         exp_pc;
        int         exp_load;
        logic [4:0] exp_addr;
        int         exp_exec;
        int         exp_strobe_k;
        int         exp_lat;
        logic       exp_halt;
    } vec_t;

    vec_t       vecs[8];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_ret = 8'd0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int pack1();
        return int'({d1_rom_cs, d1_rom_oe, d1_ir_en, d1_pc_en, d1_load_en,
                     d1_exec_req, d1_halted, d1_inst_addr, d1_retired});
    endfunction

    function automatic int pack2();
        return int'({d2_rom_cs, d2_rom_oe, d2_ir_en, d2_pc_en, d2_load_en,
                     d2_exec_req, d2_halted, d2_inst_addr, d2_retired});
    endfunction

    // Entered with instance 1 sampled in its first FETCH cycle.
    task automatic run_instr(input int idx, input vec_t v);
        int   k = 1, rom = 0, ir_k = 0, pc = 0, ld = 0, ex = 0, strobe_k = 0, lat = 0;
        logic [4:0] addr = 5'd0;
        logic prev_rom = 1'b1, halted = 1'b0, overlap = 1'b0, early_bad = 1'b0, done = 1'b0;
        OPCODE = v.op; ZERO = v.zero; ImediateADDR = v.imm; EXEC_ACK = v.stray_ack;
        I_Flag = ~I_Flag;
        while (!done && k < 60) begin
            if (d1_rom_cs && d1_rom_oe) rom++;
            if (d1_ir_en && ir_k == 0) ir_k = k;
            if (d1_pc_en) begin pc++; strobe_k = k; end
            if (d1_load_en) begin ld++; strobe_k = k; addr = d1_inst_addr; end
            if ((d1_pc_en && d1_load_en) || (d1_ir_en && (d1_pc_en || d1_load_en))) overlap = 1'b1;
            if (strobe_k == 0 && d1_retired != exp_ret) early_bad = 1'b1;
            if (d1_exec_req) begin ex++; EXEC_ACK = (ex == v.ack_delay); end
            else EXEC_ACK = v.stray_ack;
            if (d1_halted) begin
                halted = 1'b1; done = 1'b1; lat = k;
            end else begin
                prev_rom = d1_rom_cs;
                tick();
                k++;
                if (d1_rom_cs && !prev_rom) begin done = 1'b1; lat = k - 1; end
            end
        end
        EXEC_ACK = 1'b0;
        chk($sformatf("v%0d_done", idx), int'(done), 1);
        chk($sformatf("v%0d_rom_cycles", idx), rom, 2);
        chk($sformatf("v%0d_ir_cycle", idx), ir_k, 2);
        chk($sformatf("v%0d_pc_en", idx), pc, v.exp_pc);
        chk($sformatf("v%0d_load_en", idx), ld, v.exp_load);
        if (v.exp_load != 0) chk($sformatf("v%0d_inst_addr", idx), int'(addr), int'(v.exp_addr));
        chk($sformatf("v%0d_exec_cycles", idx), ex, v.exp_exec);
        chk($sformatf("v%0d_strobe_cycle", idx), strobe_k, v.exp_strobe_k);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_halted", idx), int'(halted), int'(v.exp_halt));
        chk($sformatf("v%0d_overlap", idx), int'(overlap), 0);
        chk($sformatf("v%0d_retired_early", idx), int'(early_bad), 0);
        if ((v.exp_pc + v.exp_load) != 0 && exp_ret != 8'hFF) exp_ret = exp_ret + 8'd1;
        chk($sformatf("v%0d_retired", idx), int'(d1_retired), int'(exp_ret));
    endtask

    initial begin
        int k, ir2, pc2, rom2, lat2, pcs;
        logic prev;
        logic found;

        //         op     z     imm    dly stray pc ld addr   ex sk lat halt
        vecs[0] = '{4'h0, 1'b0, 7'h00, 0, 1'b0, 1, 0, 5'h00, 0, 4, 4, 1'b0};
        vecs[1] = '{4'hD, 1'b0, 7'h73, 0, 1'b0, 0, 1, 5'h13, 0, 4, 4, 1'b0};
        vecs[2] = '{4'hE, 1'b0, 7'h2A, 0, 1'b0, 1, 0, 5'h00, 0, 4, 4, 1'b0};
        vecs[3] = '{4'hE, 1'b1, 7'h25, 0, 1'b0, 0, 1, 5'h05, 0, 4, 4, 1'b0};
        vecs[4] = '{4'h3, 1'b0, 7'h11, 5, 1'b1, 1, 0, 5'h00, 5, 9, 9, 1'b0};
        vecs[5] = '{4'h7, 1'b1, 7'h00, 1, 1'b0, 1, 0, 5'h00, 1, 5, 5, 1'b0};
        vecs[6] = '{4'hD, 1'b1, 7'h1F, 0, 1'b1, 0, 1, 5'h1F, 0, 4, 4, 1'b0};
        vecs[7] = '{4'hF, 1'b0, 7'h00, 0, 1'b0, 0, 0, 5'h00, 0, 0, 4, 1'b1};

        // Reset state of both instances
        repeat (3) tick();
        chk("reset_outputs_d1", pack1(), 0);
        chk("reset_outputs_d2", pack2(), 0);

        // ROM_WAIT=3 instance: fetch timing, then reset mid-FETCH
        START2 = 1'b1; RST_N2 = 1'b1; OPCODE = 4'h0;
        tick();
        START2 = 1'b0;
        k = 1; prev = 1'b1; ir2 = 0; pc2 = 0; rom2 = 0; lat2 = 0;
        while (lat2 == 0 && k < 30) begin
            if (d2_rom_cs) rom2++;
            if (d2_ir_en && ir2 == 0) ir2 = k;
            if (d2_pc_en) pc2 = k;
            prev = d2_rom_cs;
            tick();
            k++;
            if (d2_rom_cs && !prev) lat2 = k - 1;
        end
        chk("w3_rom_cycles", rom2, 4);
        chk("w3_ir_cycle", ir2, 4);
        chk("w3_pc_cycle", pc2, 6);
        chk("w3_latency", lat2, 6);
        chk("w3_retired", int'(d2_retired), 1);
        tick();
        chk("w3_still_fetch", int'(d2_rom_cs & ~d2_ir_en), 1);
        RST_N2 = 1'b0;
        tick();
        chk("w3_reset_mid_fetch", pack2(), 0);
        RST_N2 = 1'b1;
        tick();
        chk("w3_idle_after_reset", pack2(), 0);

        // ROM_WAIT=1 instance: table of instructions ending in HALT
        RST_N = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 8; i++) run_instr(i, vecs[i]);

        for (int i = 0; i < 20; i++) begin
            START = i[0];
            tick();
            chk("halt_hold", int'({d1_halted, d1_rom_cs, d1_ir_en, d1_pc_en, d1_load_en, d1_exec_req}), 32);
        end
        START = 1'b0;
        RST_N = 1'b0;
        tick();
        chk("halt_reset", pack1(), 0);
        RST_N = 1'b1;
        tick();
        chk("idle_without_start", pack1(), 0);
        exp_ret = 8'd0;

        // Reset while EXEC waits for an acknowledge
        START = 1'b1;
        tick();
        START = 1'b0; OPCODE = 4'h3; EXEC_ACK = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (d1_exec_req) found = 1'b1;
        end
        chk("exec_reached", int'(found), 1);
        tick(); tick();
        chk("exec_held_no_ack", int'(d1_exec_req), 1);
        RST_N = 1'b0;
        tick();
        chk("exec_reset_drops_req", pack1(), 0);
        RST_N = 1'b1;

        // 300 NOPs: RETIRED saturates at 255
        OPCODE = 4'h0; START = 1'b1;
        tick();
        START = 1'b0;
        pcs = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (d1_pc_en) begin
                pcs++;
                if (pcs == 254) chk("sat_254", int'(d1_retired), 254);
                if (pcs == 255) chk("sat_255", int'(d1_retired), 255);
                if (pcs == 300) chk("sat_300", int'(d1_retired), 255);
            end
        end
        chk("nop_count", pcs, 300);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ROM_WAIT, default 1, ROM access cycles with ROM_CS/ROM_OE held before MIR load (legal 1..7).
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  level; begins fetching from IDLE.
REQ-005 OPCODE  input  4  opcode field from the MIR.
REQ-006 I_Flag  input  1  immediate flag from the MIR; passed to the datapath, no effect on sequencing.
REQ-007 ImediateADDR  input  7  immediate/branch field from the MIR.
REQ-008 ZERO  input  1  datapath zero flag for conditional branches.
REQ-009 EXEC_ACK  input  1  datapath completion for the current instruction.
REQ-010 ROM_CS, ROM_OE  output  1 each  instruction ROM select/output enable.
REQ-011 IR_EN  output  1  MIR load strobe.
REQ-012 PC_EN  output  1  PC increment strobe.
REQ-013 LOAD_EN  output  1  PC side-load strobe.
REQ-014 InstADDR  output  5  branch target for the PC side-load, equal to ImediateADDR[4:0].
REQ-015 EXEC_REQ  output  1  execute request to the datapath.
REQ-016 HALTED  output  1  high in HALT state.
REQ-017 RETIRED  output  8  count of retired instructions.

Function
REQ-018 States: IDLE, FETCH, LOAD, DECODE, EXEC, BRANCH, ADVANCE, HALT; all outputs Moore-decoded from the state register (no combinational input-to-output path).
REQ-019 IDLE: all strobes 0; START=1 -> FETCH.
REQ-020 FETCH: ROM_CS=ROM_OE=1; stays exactly ROM_WAIT cycles via wait counter, then -> LOAD.
REQ-021 LOAD: ROM_CS=ROM_OE=IR_EN=1 for one cycle -> DECODE.
REQ-022 DECODE (one cycle, all strobes 0): OPCODE=4'hF -> HALT; 4'hD -> BRANCH; 4'hE with ZERO=1 -> BRANCH; 4'hE with ZERO=0 -> ADVANCE; 4'h0 -> ADVANCE; any other -> EXEC.
REQ-023 EXEC: EXEC_REQ=1 held until EXEC_ACK sampled 1; then -> ADVANCE. EXEC_ACK outside EXEC is ignored.
REQ-024 BRANCH: LOAD_EN=1 for one cycle, InstADDR=ImediateADDR[4:0] (bits 6:5 ignored) -> FETCH.
REQ-025 ADVANCE: PC_EN=1 for one cycle -> FETCH; PC wrap 31->0 belongs to the PC, not the sequencer.
REQ-026 PC_EN and LOAD_EN are never high in the same cycle; IR_EN is never high while PC_EN or LOAD_EN is high.
REQ-027 RETIRED increments by 1 on each entry to ADVANCE or BRANCH; it saturates at 255 (no wrap).
REQ-028 HALT: HALTED=1, all other strobes 0; START is ignored; only reset exits.
REQ-029 START is sampled only in IDLE; deassertion mid-program has no effect.
REQ-030 NOP latency is ROM_WAIT+3 cycles from FETCH entry to the next FETCH entry; a taken branch has the same latency.

Reset
REQ-031 RST_N=0 at a rising edge -> state IDLE, wait counter 0, RETIRED 0, all outputs 0 on the following cycle, regardless of the current state (including mid-EXEC or HALT).
REQ-032 A reset during EXEC drops EXEC_REQ without waiting for EXEC_ACK.

Structure
REQ-033 The shared package fetch_pkg holds the state enum and the opcode constants OP_NOP=4'h0, OP_BR=4'hD, OP_BRZ=4'hE, OP_HLT=4'hF.
REQ-034 Single module, no sub-module; the wait counter and the RETIRED counter are inline.

Verification
REQ-035 Reset, START=1, OPCODE=0, ROM_WAIT=1 -> ROM_CS/OE 2 cycles, IR_EN at cycle 2, PC_EN at cycle 4, RETIRED=1.
REQ-036 OPCODE=4'hD, ImediateADDR=7'h73 -> LOAD_EN one cycle, InstADDR=5'h13, PC_EN stays 0.
REQ-037 OPCODE=4'hE with ZERO=0, then again with ZERO=1 -> PC_EN the first time, LOAD_EN the second time.
REQ-038 OPCODE=4'h3, EXEC_ACK delayed 5 cycles -> EXEC_REQ high 5 cycles, then PC_EN; RETIRED unchanged until then.
REQ-039 OPCODE=4'hF -> HALTED=1 held for 20 cycles despite START pulses; RST_N low one edge -> IDLE, RETIRED=0.
REQ-040 300 NOPs -> RETIRED saturates at 255; reset asserted mid-FETCH at ROM_WAIT=3 -> outputs 0 on the next cycle.
